// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port RAM between the CPU load/store path (port C) and the
// debug/program-loader path (port D). Each access runs IDLE -> ISSUE -> (read)
// RDATA -> IDLE, matching the RAM's one-cycle registered read latency.
// Optional build macro: RAM_ARB_ROUND_ROBIN_EN
//   undefined : C has fixed priority; D is forced through after STARVE_LIMIT
//               consecutive C grants while D waits.
//   defined   : on a simultaneous request the port opposite the last grant wins.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              req_any;
  logic              grant_d;
  logic              win_d;
  logic              we_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic              last_grant_d;
`else
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_cnt;
`endif

  // Winner selection for the IDLE decision
  always_comb begin
    req_any = cpu_req | dbg_req;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (cpu_req && dbg_req) begin
      grant_d = ~last_grant_d;
    end else begin
      grant_d = dbg_req;
    end
`else
    grant_d = dbg_req & (~cpu_req | (starve_cnt >= STARVE_W'(STARVE_LIMIT)));
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = we_q ? IDLE : RDATA;
      RDATA:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winning request and the returned read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_address <= '0;
      ram_data    <= '0;
      we_q        <= 1'b0;
      win_d       <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (state == IDLE && req_any) begin
        ram_address <= grant_d ? dbg_addr  : cpu_addr;
        ram_data    <= grant_d ? dbg_wdata : cpu_wdata;
        we_q        <= grant_d ? dbg_we    : cpu_we;
        win_d       <= grant_d;
      end
      if (state == RDATA) begin
        if (win_d) begin
          dbg_rdata_q <= ram_q;
        end else begin
          cpu_rdata_q <= ram_q;
        end
      end
    end
  end

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Remember which port was granted last
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_d <= 1'b1;
    end else if (state == IDLE && req_any) begin
      last_grant_d <= grant_d;
    end
  end
`else
  // Count C grants taken while D is waiting; only updated at IDLE decisions
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!dbg_req || grant_d) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end
`endif

  // Outputs; read data is forwarded straight from ram_q in the ack cycle so
  // it is valid together with the ack, then held by the capture register
  always_comb begin
    ram_wren  = (state == ISSUE) &  we_q;
    ram_rden  = (state == ISSUE) & ~we_q;
    cpu_ack   = ~win_d & (((state == ISSUE) & we_q) | (state == RDATA));
    dbg_ack   =  win_d & (((state == ISSUE) & we_q) | (state == RDATA));
    busy      = (state != IDLE);
    cpu_stall = cpu_req & ~cpu_ack;
    cpu_rdata = (state == RDATA && !win_d) ? ram_q : cpu_rdata_q;
    dbg_rdata = (state == RDATA &&  win_d) ? ram_q : dbg_rdata_q;
  end

endmodule
